// File: rtl/imem_load_ctrl_if.sv
// rtl/imem_load_ctrl_if.sv - host load stream, imem byte write port and core status bundle
// The controller takes the slave side; the boot/debug host and imem take the master side.
interface imem_load_ctrl_if;
  logic        load_start;
  logic [31:0] load_base;
  logic [7:0]  load_count;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;

  modport slave (
    input  load_start, load_base, load_count, load_valid, load_data,
    output load_ready, mem_we, mem_waddr, mem_wdata, core_hold, busy, done, error
  );

  modport master (
    output load_start, load_base, load_count, load_valid, load_data,
    input  load_ready, mem_we, mem_waddr, mem_wdata, core_hold, busy, done, error
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - program loader: 32-bit host words to little-endian imem byte writes
// Holds core fetch while a load runs and until the first successful load completes.
module imem_load_ctrl #(
  parameter int MEM_BYTES     = 128,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input logic            clk,
  input logic            reset,
  imem_load_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state, state_n;
  logic [31:0] base_q, base_n;
  logic [7:0]  count_q, count_n;
  logic [7:0]  idx_q, idx_n;
  logic [1:0]  k_q, k_n;
  logic [31:0] word_q, word_n;
  logic        loaded_q, loaded_n;

  // End address is formed one bit wider so a huge base cannot wrap into range.
  logic [32:0] load_end;
  logic        range_bad;
  assign load_end  = {1'b0, bus.load_base} + {23'b0, bus.load_count, 2'b00};
  assign range_bad = (bus.load_base[1:0] != 2'b00) || (load_end > 33'(MEM_BYTES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      base_q   <= 32'd0;
      count_q  <= 8'd0;
      idx_q    <= 8'd0;
      k_q      <= 2'd0;
      word_q   <= 32'd0;
      loaded_q <= !HOLD_AT_RESET;
    end else begin
      state    <= state_n;
      base_q   <= base_n;
      count_q  <= count_n;
      idx_q    <= idx_n;
      k_q      <= k_n;
      word_q   <= word_n;
      loaded_q <= loaded_n;
    end
  end

  always_comb begin
    state_n  = state;
    base_n   = base_q;
    count_n  = count_q;
    idx_n    = idx_q;
    k_n      = k_q;
    word_n   = word_q;
    loaded_n = loaded_q;
    case (state)
      S_IDLE: begin
        if (bus.load_start) begin
          base_n  = bus.load_base;
          count_n = bus.load_count;
          idx_n   = 8'd0;
          if (range_bad)
            state_n = S_ERR;
          else if (bus.load_count == 8'd0)
            state_n = S_DONE;
          else
            state_n = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (bus.load_valid) begin
          word_n  = bus.load_data;
          k_n     = 2'd0;
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        k_n = k_q + 2'd1;
        if (k_q == 2'd3) begin
          idx_n   = idx_q + 8'd1;
          state_n = ((idx_q + 8'd1) == count_q) ? S_DONE : S_ACCEPT;
        end
      end
      S_DONE: begin
        loaded_n = 1'b1;
        state_n  = S_IDLE;
      end
      S_ERR: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Write port is a pure decode of state and registers, so it changes only on clk.
  logic [31:0] word_shifted;
  always_comb begin
    word_shifted  = word_q >> {k_q, 3'b000};
    bus.mem_we    = (state == S_WRITE);
    bus.mem_waddr = 32'd0;
    bus.mem_wdata = 8'd0;
    if (state == S_WRITE) begin
      bus.mem_waddr = base_q + {22'b0, idx_q, k_q};
      bus.mem_wdata = word_shifted[7:0];
    end
  end

  assign bus.load_ready = (state == S_ACCEPT);
  assign bus.busy       = (state == S_ACCEPT) || (state == S_WRITE);
  assign bus.done       = (state == S_DONE);
  assign bus.error      = (state == S_ERR);
  assign bus.core_hold  = bus.busy || bus.done || !loaded_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - scoreboard bench for imem_load_ctrl with directed load vectors
module tb_imem_load_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_load_ctrl_if bus();

  imem_load_ctrl #(.MEM_BYTES(128), .HOLD_AT_RESET(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [39:0] exp_wr[$];   // {addr, data}
  logic [1:0]  exp_evt[$];  // {error, done}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_we) begin
      if (exp_wr.size() == 0)
        check("unexpected_write", {24'd0, bus.mem_waddr, bus.mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      else
        check("mem_write", {24'd0, bus.mem_waddr, bus.mem_wdata}, {24'd0, exp_wr.pop_front()});
    end
    if (bus.done || bus.error) begin
      if (exp_evt.size() == 0)
        check("unexpected_event", {62'd0, bus.error, bus.done}, 64'd0);
      else
        check("event", {62'd0, bus.error, bus.done}, {62'd0, exp_evt.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [31:0] b, input logic [7:0] c);
    bus.load_start = 1'b1;
    bus.load_base  = b;
    bus.load_count = c;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] b, input int idx, input logic [31:0] d);
    for (int k = 0; k < 4; k++)
      exp_wr.push_back({b + 32'(4 * idx + k), d[8*k +: 8]});
  endtask

  task automatic send_word(input logic [31:0] d, input int gap);
    int t;
    bus.load_valid = 1'b0;
    repeat (gap) tick();
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.load_ready && t < 30);
    if (!bus.load_ready) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    @(negedge clk);
    check("first_write_after_handshake", {63'd0, bus.mem_we}, 64'd1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!bus.done && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus.done) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      check("hold_during_done", {63'd0, bus.core_hold}, 64'd1);
      @(negedge clk);
      check("hold_released", {62'd0, bus.core_hold, bus.done}, 64'd0);
    end
  endtask

  task automatic expect_drained(input string name);
    check(name, 64'(exp_wr.size() + exp_evt.size()), 64'd0);
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.load_base  = 32'd0;
    bus.load_count = 8'd0;
    bus.load_valid = 1'b0;
    bus.load_data  = 32'd0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state: only core_hold is high, and it stays so while idle
    repeat (4) begin
      @(negedge clk);
      check("reset_outputs",
            {18'd0, bus.core_hold, bus.load_ready, bus.mem_we, bus.busy, bus.done, bus.error,
             bus.mem_waddr, bus.mem_wdata},
            {18'd0, 6'b100000, 40'd0});
    end

    // Single word at base 0
    tick();
    push_word(32'd0, 0, 32'h0094_0333);
    exp_evt.push_back(2'b01);
    start_load(32'd0, 8'd1);
    send_word(32'h0094_0333, 0);
    wait_done();
    expect_drained("drain_single");

    // Two words at base 8, valid gapped then held across WRITE; a stray start is ignored
    tick();
    push_word(32'd8, 0, 32'hA1B2_C3D4);
    push_word(32'd8, 1, 32'h1122_3344);
    exp_evt.push_back(2'b01);
    start_load(32'd8, 8'd2);
    start_load(32'd64, 8'd3);
    send_word(32'hA1B2_C3D4, 3);
    send_word(32'h1122_3344, 0);
    wait_done();
    expect_drained("drain_two_words");

    // Misaligned base and overrun both rejected without writes
    tick();
    exp_evt.push_back(2'b10);
    start_load(32'd2, 8'd1);
    @(negedge clk);
    check("misaligned_error", {62'd0, bus.error, bus.busy}, 64'd2);
    tick();
    exp_evt.push_back(2'b10);
    start_load(32'd124, 8'd2);
    @(negedge clk);
    check("overrun_error", {62'd0, bus.error, bus.busy}, 64'd2);
    repeat (3) tick();
    expect_drained("drain_errors");

    // Zero-length load completes the cycle after start
    exp_evt.push_back(2'b01);
    start_load(32'd0, 8'd0);
    @(negedge clk);
    check("zero_count_done", {62'd0, bus.done, bus.mem_we}, 64'd2);
    tick();

    // Last legal word ends exactly at MEM_BYTES
    push_word(32'd124, 0, 32'hDEAD_BEEF);
    exp_evt.push_back(2'b01);
    start_load(32'd124, 8'd1);
    send_word(32'hDEAD_BEEF, 1);
    wait_done();
    expect_drained("drain_last_word");

    // Reset during the second byte stops the write stream
    tick();
    exp_wr.push_back({32'd0, 8'h0D});
    exp_wr.push_back({32'd1, 8'hF0});
    start_load(32'd0, 8'd1);
    send_word(32'hCAFE_F00D, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("after_mid_reset",
          {59'd0, bus.mem_we, bus.busy, bus.load_ready, bus.done, bus.core_hold}, 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_after_reset", {62'd0, bus.core_hold, bus.busy}, 64'd2);
    expect_drained("drain_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
